// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Resolution-side partner of the fetch-stage branch predictor. Every prediction
// issued at fetch is queued in order. When the ALU resolves the oldest
// in-flight branch, the block compares the outcome with the queued prediction.
// It then emits a training update, and on a mispredict it also emits a
// pipeline flush and a fetch redirect.
//
// Ports
//   i_Clk, i_Reset         clock; asynchronous active-high reset
//   i_PRED_valid/pc/taken  prediction issued at fetch
//   o_PRED_ready           queue accepts a prediction this cycle
//   i_ALU_valid/taken/...  resolution of the oldest in-flight branch
//   o_UPD_*                one-cycle predictor training event
//   o_flush                squash window, FLUSH_CYCLES long after a mispredict
//   o_redirect_valid/pc    one-cycle fetch redirect
//   o_branch_count         saturating count of resolved branches
//   o_mispredict_count     saturating count of mispredicts
//   o_error                sticky: resolution arrived with an empty queue
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int DEPTH         = 4,
    parameter int FLUSH_CYCLES  = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_PRED_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_PRED_pc,
    input  logic                     i_PRED_taken,
    output logic                     o_PRED_ready,
    input  logic                     i_ALU_valid,
    input  logic                     i_ALU_taken,
    input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
    output logic                     o_UPD_valid,
    output logic [ADDRESS_WIDTH-1:0] o_UPD_pc,
    output logic                     o_UPD_taken,
    output logic                     o_UPD_mispredict,
    output logic                     o_flush,
    output logic                     o_redirect_valid,
    output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
    output logic [CNT_WIDTH-1:0]     o_branch_count,
    output logic [CNT_WIDTH-1:0]     o_mispredict_count,
    output logic                     o_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t                   state;
    logic [FC_W-1:0]          flush_cnt;

    logic [ADDRESS_WIDTH-1:0] q_pc    [DEPTH];
    logic                     q_taken [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [OCC_W-1:0]         count;

    logic                     enq;
    logic                     resolve;
    logic                     mispredict;
    logic                     empty_hit;
    logic [ADDRESS_WIDTH-1:0] head_pc;
    logic                     head_taken;

    // Ready depends only on registered state, so a pop in the same cycle never
    // opens a slot for a push.
    assign o_PRED_ready = (state == ST_IDLE) && (count < OCC_W'(DEPTH));

    assign enq        = i_PRED_valid && o_PRED_ready;
    assign head_pc    = q_pc[rd_ptr];
    assign head_taken = q_taken[rd_ptr];
    assign resolve    = (state == ST_IDLE) && i_ALU_valid && (count != '0);
    assign empty_hit  = (state == ST_IDLE) && i_ALU_valid && (count == '0);
    assign mispredict = resolve && (head_taken != i_ALU_taken);

    // NOTE: queue storage has no reset; validity is tracked by count and the
    // pointers, so clearing the array would only add reset fan-out.
    always_ff @(posedge i_Clk) begin
        if (enq) begin
            q_pc[wr_ptr]    <= i_PRED_pc;
            q_taken[wr_ptr] <= i_PRED_taken;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state              <= ST_IDLE;
            flush_cnt          <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            o_UPD_valid        <= 1'b0;
            o_UPD_pc           <= '0;
            o_UPD_taken        <= 1'b0;
            o_UPD_mispredict   <= 1'b0;
            o_flush            <= 1'b0;
            o_redirect_valid   <= 1'b0;
            o_redirect_pc      <= '0;
            o_branch_count     <= '0;
            o_mispredict_count <= '0;
            o_error            <= 1'b0;
        end else begin
            o_UPD_valid      <= 1'b0;
            o_redirect_valid <= 1'b0;

            if (empty_hit) begin
                o_error <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (mispredict) begin
                        // Everything younger than the mispredicted branch is
                        // wrong-path, including a prediction arriving now.
                        wr_ptr           <= '0;
                        rd_ptr           <= '0;
                        count            <= '0;
                        state            <= ST_FLUSH;
                        flush_cnt        <= FC_W'(FLUSH_CYCLES - 1);
                        o_flush          <= 1'b1;
                        o_redirect_valid <= 1'b1;
                        o_redirect_pc    <= i_ALU_taken ? i_ALU_target
                                                        : head_pc + ADDRESS_WIDTH'(1);
                    end else begin
                        if (enq) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                        if (resolve) begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                        if (enq && !resolve) begin
                            count <= count + OCC_W'(1);
                        end else if (!enq && resolve) begin
                            count <= count - OCC_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= ST_IDLE;
                        o_flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (resolve) begin
                o_UPD_valid      <= 1'b1;
                o_UPD_pc         <= head_pc;
                o_UPD_taken      <= i_ALU_taken;
                o_UPD_mispredict <= mispredict;
                if (o_branch_count != '1) begin
                    o_branch_count <= o_branch_count + CNT_WIDTH'(1);
                end
                if (mispredict && (o_mispredict_count != '1)) begin
                    o_mispredict_count <= o_mispredict_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
